// File: rtl/zl_ts_null_scheduler.sv
// Packet-level scheduler feeding the DVB-S encoder: forwards whole user TS packets
// when available, otherwise emits generated null packets, keeping 188-byte alignment.
module zl_ts_null_scheduler #(
  parameter int          Pkt_len   = 188,
  parameter logic [7:0]  Sync_byte = 8'h47,
  parameter logic [12:0] Null_pid  = 13'h1FFF,
  parameter int          Cnt_width = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           data_in,
  input  logic                 data_in_req,
  output logic                 data_in_ack,
  input  logic                 pkt_ready,
  input  logic                 force_null,
  output logic [7:0]           data_out,
  output logic                 data_out_req,
  input  logic                 data_out_ack,
  output logic                 pkt_start,
  output logic                 null_active,
  output logic [Cnt_width-1:0] null_count,
  output logic [Cnt_width-1:0] drop_count
);

  typedef enum logic [1:0] {S_SELECT, S_HUNT, S_PASS, S_NULL} state_t;

  localparam logic [7:0]           LAST = 8'(Pkt_len - 1);
  localparam logic [Cnt_width-1:0] ONE  = {{(Cnt_width-1){1'b0}}, 1'b1};

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       null_inc, drop_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_SELECT;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    data_out     = 8'h00;
    data_out_req = 1'b0;
    data_in_ack  = 1'b0;
    pkt_start    = 1'b0;
    null_active  = 1'b0;
    null_inc     = 1'b0;
    drop_inc     = 1'b0;
    case (state)
      S_SELECT: begin
        cnt_nxt = 8'd0;
        if (!force_null && pkt_ready && data_in_req)
          state_nxt = (data_in == Sync_byte) ? S_PASS : S_HUNT;
        else
          state_nxt = S_NULL;
      end
      S_HUNT: begin
        // The sync byte itself is left on the input so PASS presents it as byte 0.
        data_in_ack = data_in_req && (data_in != Sync_byte);
        drop_inc    = data_in_ack;
        if (!data_in_req) begin
          state_nxt = S_SELECT;
        end else if (data_in == Sync_byte) begin
          state_nxt = S_PASS;
          cnt_nxt   = 8'd0;
        end
      end
      S_PASS: begin
        data_out     = data_in;
        data_out_req = data_in_req;
        data_in_ack  = data_out_ack;
        pkt_start    = (cnt == 8'd0);
        if (data_in_req && data_out_ack) begin
          if (cnt == LAST) begin
            state_nxt = S_SELECT;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      S_NULL: begin
        data_out_req = 1'b1;
        null_active  = 1'b1;
        pkt_start    = (cnt == 8'd0);
        case (cnt)
          8'd0:    data_out = Sync_byte;
          8'd1:    data_out = {3'b000, Null_pid[12:8]};
          8'd2:    data_out = Null_pid[7:0];
          8'd3:    data_out = 8'h10;
          default: data_out = 8'hFF;
        endcase
        if (data_out_ack) begin
          if (cnt == LAST) begin
            null_inc  = 1'b1;
            state_nxt = S_SELECT;
            cnt_nxt   = 8'd0;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
      end
      default: state_nxt = S_SELECT;
    endcase
  end

  // Status counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      null_count <= '0;
      drop_count <= '0;
    end else begin
      if (null_inc && (null_count != '1)) null_count <= null_count + ONE;
      if (drop_inc && (drop_count != '1)) drop_count <= drop_count + ONE;
    end
  end

endmodule
